// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared direction/mode encodings and the load-value clamp.
//  Revision    : 1.0  initial release
// ============================================================================
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Operates on 32-bit values so one function serves every counter width.
    function automatic logic [31:0] clamp_to_max(input logic [31:0] value,
                                                 input logic [31:0] max_value);
        return (value > max_value) ? max_value : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/counter_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : counter_prescaler
//  Description : Emits a one-cycle STEP strobe every PRESCALE enabled cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module counter_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic ENABLE,
    input  logic CLEAR,
    output logic STEP
);

    generate
        if (PRESCALE <= 1) begin : g_passthrough
            logic w_unused;
            assign w_unused = &{1'b0, CLOCK, RESET, CLEAR};
            assign STEP     = ENABLE;
        end else begin : g_count
            localparam int              CW     = $clog2(PRESCALE);
            localparam logic [CW-1:0]   c_last = CW'(PRESCALE - 1);

            logic [CW-1:0] r_count;

            assign STEP = ENABLE && (r_count == c_last);

            always_ff @(posedge CLOCK) begin
                if (RESET || CLEAR) begin
                    r_count <= '0;
                end else if (ENABLE) begin
                    r_count <= (r_count == c_last) ? '0 : r_count + CW'(1);
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mode_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mode_counter
//  Description : Up/down counter with programmable top, wrap/saturate mode,
//                synchronous load, prescaler and TC/WRAP/OVF status.
//  Revision    : 1.0  initial release
// ============================================================================
module mode_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_VALUE = (1 << WIDTH) - 1,
    parameter int PRESCALE  = 1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VALUE,
    input  logic             UP,
    input  logic             SATURATE,
    input  logic             CLEAR_OVF,
    output logic [WIDTH-1:0] OUT,
    output logic             TC,
    output logic             WRAP,
    output logic             OVF
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX_VALUE);

    logic             w_step;
    logic             w_at_top;
    logic             w_at_bottom;
    logic             w_boundary;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] r_out;
    logic             r_wrap;
    logic             r_ovf;

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .ENABLE (ENABLE),
        .CLEAR  (LOAD),
        .STEP   (w_step)
    );

    assign w_at_top       = (r_out == c_max);
    assign w_at_bottom    = (r_out == '0);
    assign w_boundary     = w_step && ((UP == DIR_UP) ? w_at_top : w_at_bottom);
    assign w_load_clamped = WIDTH'(clamp_to_max(32'(LOAD_VALUE), 32'(MAX_VALUE)));

    // The boundary cases never form OUT+1 or OUT-1, so a non-power-of-two
    // top value wraps to exactly 0 / MAX_VALUE.
    always_comb begin
        w_next = r_out;
        if (UP == DIR_UP) begin
            if (w_at_top) begin
                w_next = (SATURATE == MODE_SAT) ? c_max : '0;
            end else begin
                w_next = r_out + WIDTH'(1);
            end
        end else begin
            if (w_at_bottom) begin
                w_next = (SATURATE == MODE_SAT) ? '0 : c_max;
            end else begin
                w_next = r_out - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_out  <= '0;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (LOAD) begin
            r_out  <= w_load_clamped;
            r_wrap <= 1'b0;
            if (CLEAR_OVF) begin
                r_ovf <= 1'b0;
            end
        end else begin
            r_wrap <= w_boundary;
            if (w_step) begin
                r_out <= w_next;
            end
            // A boundary step on the same edge as a clear keeps the flag set.
            if (w_boundary) begin
                r_ovf <= 1'b1;
            end else if (CLEAR_OVF) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign OUT  = r_out;
    assign TC   = (UP == DIR_UP) ? w_at_top : w_at_bottom;
    assign WRAP = r_wrap;
    assign OVF  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mode_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mode_counter
//  Description : Randomized and directed bench for two mode_counter configs
//                against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mode_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       ld  = 1'b0;
    logic [3:0] lv  = '0;
    logic       up  = 1'b1;
    logic       sat = 1'b0;
    logic       clr = 1'b0;

    logic [3:0] out_a, out_b;
    logic       tc_a, tc_b, wrap_a, wrap_b, ovf_a, ovf_b;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state per instance: index 0 = defaults, index 1 = MAX 9 / PRESCALE 3.
    int m_max [2] = '{15, 9};
    int m_pre [2] = '{1, 3};
    int s_out [2];
    int s_cnt [2];
    int s_wrap[2];
    int s_ovf [2];

    always #5 clk = ~clk;

    mode_counter dut_a (
        .CLOCK(clk), .RESET(rst), .ENABLE(en), .LOAD(ld), .LOAD_VALUE(lv),
        .UP(up), .SATURATE(sat), .CLEAR_OVF(clr),
        .OUT(out_a), .TC(tc_a), .WRAP(wrap_a), .OVF(ovf_a)
    );

    mode_counter #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(3)) dut_b (
        .CLOCK(clk), .RESET(rst), .ENABLE(en), .LOAD(ld), .LOAD_VALUE(lv),
        .UP(up), .SATURATE(sat), .CLEAR_OVF(clr),
        .OUT(out_b), .TC(tc_b), .WRAP(wrap_b), .OVF(ovf_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Counting on the ring 0..M: wrap mode is plain modular arithmetic,
    // saturate mode pins at the end of the range.
    task automatic model_edge(input int k);
        int m;
        bit hit;
        m   = m_max[k];
        hit = 1'b0;
        if (rst) begin
            s_out[k] = 0; s_cnt[k] = 0; s_wrap[k] = 0; s_ovf[k] = 0;
        end else if (ld) begin
            s_out[k]  = (int'(lv) > m) ? m : int'(lv);
            s_cnt[k]  = 0;
            s_wrap[k] = 0;
            if (clr) s_ovf[k] = 0;
        end else begin
            if (en) begin
                s_cnt[k]++;
                if (s_cnt[k] == m_pre[k]) begin
                    s_cnt[k] = 0;
                    hit = up ? (s_out[k] == m) : (s_out[k] == 0);
                    if (hit && sat)  s_out[k] = s_out[k];
                    else if (up)     s_out[k] = (s_out[k] + 1) % (m + 1);
                    else             s_out[k] = (s_out[k] + m) % (m + 1);
                end
            end
            s_wrap[k] = hit;
            if (hit)      s_ovf[k] = 1;
            else if (clr) s_ovf[k] = 0;
        end
    endtask

    task automatic check_all();
        int tc0, tc1;
        tc0 = up ? (s_out[0] == m_max[0]) : (s_out[0] == 0);
        tc1 = up ? (s_out[1] == m_max[1]) : (s_out[1] == 0);
        check("a.out",  out_a,  s_out[0]);
        check("a.tc",   tc_a,   tc0);
        check("a.wrap", wrap_a, s_wrap[0]);
        check("a.ovf",  ovf_a,  s_ovf[0]);
        check("b.out",  out_b,  s_out[1]);
        check("b.tc",   tc_b,   tc1);
        check("b.wrap", wrap_b, s_wrap[1]);
        check("b.ovf",  ovf_b,  s_ovf[1]);
    endtask

    // Apply one cycle of inputs, advance model on the edge, check mid-cycle.
    task automatic cyc(input bit i_rst, input bit i_ld, input int i_lv, input bit i_en,
                       input bit i_up, input bit i_sat, input bit i_clr);
        rst = i_rst; ld = i_ld; lv = 4'(i_lv); en = i_en;
        up = i_up; sat = i_sat; clr = i_clr;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            s_out[k] = 0; s_cnt[k] = 0; s_wrap[k] = 0; s_ovf[k] = 0;
        end

        // Reset then count up through a full wrap.
        cyc(1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 40; i++) cyc(0, 0, 0, 1, 1, 0, 0);

        // Down count from 2 through the bottom wrap; oversize load clamps.
        cyc(0, 1, 2, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 12, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0, 0);

        // Saturate at the top; clear during boundary steps, then clear alone.
        cyc(0, 1, 14, 0, 1, 1, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1, 1, 1);
        cyc(0, 1, 3, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 1, 1, 1);
        cyc(0, 0, 0, 0, 1, 1, 0);

        // Enable gaps and loads in the middle of a prescale period.
        cyc(0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, 0, 0);
        cyc(0, 1, 5, 1, 1, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 1, 0, 0);

        // Reset colliding with load mid-prescale, then resume.
        cyc(0, 1, 7, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        cyc(1, 1, 9, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 1, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 11) == 0),
                int'($urandom_range(0, 15)),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 7) != 0) ^ (i >= 1500),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
